note_step_sequencer: RTL and testbench

Programmable step sequencer that sits directly upstream of the note-to-interval decoder. It holds a loop of NUM_STEPS 4-bit note codes and advances through them at a runtime-programmable tempo. Each step's code is presented on `note`, and the output drops to REST for the articulation gap at the end of the step. The `note` output drives the decoder's `note` input without glue logic.

---
 rtl/note_step_sequencer.sv | 111 +++++++++++
 tb/tb_note_step_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/note_step_sequencer.sv
// Step sequencer: loops through NUM_STEPS stored 4-bit note codes at a programmable tempo,
// inserting a REST articulation gap at the end of each step when gate_ticks < step_ticks.
module note_step_sequencer #(
   parameter int NUM_STEPS = 8,
   parameter int IDX_W     = $clog2(NUM_STEPS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             play,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_addr,
   input  logic [3:0]       wr_note,
   input  logic [23:0]      step_ticks,
   input  logic [23:0]      gate_ticks,
   output logic [3:0]       note,
   output logic [IDX_W-1:0] step_idx,
   output logic             step_pulse,
   output logic             playing
);

   localparam logic [3:0] REST = 4'hF;

   typedef enum logic [1:0] {IDLE, SOUND, GAP} state_t;

   state_t           state, state_nxt;
   logic [3:0]       mem [NUM_STEPS];
   logic [23:0]      tcnt, tcnt_nxt;
   logic [23:0]      step_last, gate_last;
   logic [3:0]       note_nxt, note_first, note_adv;
   logic [IDX_W-1:0] idx_nxt, idx_inc;
   logic             pulse_nxt;
   logic             advance, gap_en, gap_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '{default: REST};
      end else if (wr_en) begin
         mem[wr_addr] <= wr_note;
      end
   end

   // Live >= compares so a mid-step tempo cut advances at once instead of wrapping tcnt.
   always_comb begin
      step_last  = (step_ticks == '0) ? '0 : step_ticks - 24'd1;
      gate_last  = gate_ticks - 24'd1;
      advance    = (tcnt >= step_last);
      gap_en     = (gate_ticks != '0) && (gate_ticks < step_ticks);
      gap_hit    = gap_en && (tcnt >= gate_last);
      idx_inc    = step_idx + IDX_W'(1);
      // Write-first bypass for the step being entered on this edge.
      note_first = (wr_en && (wr_addr == '0)) ? wr_note : mem[0];
      note_adv   = (wr_en && (wr_addr == idx_inc)) ? wr_note : mem[idx_inc];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tcnt       <= '0;
         note       <= REST;
         step_idx   <= '0;
         step_pulse <= 1'b0;
      end else begin
         state      <= state_nxt;
         tcnt       <= tcnt_nxt;
         note       <= note_nxt;
         step_idx   <= idx_nxt;
         step_pulse <= pulse_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (play) state_nxt = SOUND;
         end
         SOUND, GAP: begin
            if (!play)                          state_nxt = IDLE;
            else if (advance)                   state_nxt = SOUND;
            else if ((state == SOUND) && gap_hit) state_nxt = GAP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tcnt_nxt  = tcnt + 24'd1;
      note_nxt  = note;
      idx_nxt   = step_idx;
      pulse_nxt = 1'b0;
      if ((state == IDLE) || !play) begin
         tcnt_nxt = '0;
         note_nxt = REST;
         idx_nxt  = '0;
         if ((state == IDLE) && play) begin
            note_nxt  = note_first;
            pulse_nxt = 1'b1;
         end
      end else if (advance) begin
         tcnt_nxt  = '0;
         idx_nxt   = idx_inc;
         note_nxt  = note_adv;
         pulse_nxt = 1'b1;
      end else if ((state == SOUND) && gap_hit) begin
         note_nxt = REST;
      end
   end

   assign playing = (state != IDLE);

endmodule

// File: tb/tb_note_step_sequencer.sv
// Directed bench for note_step_sequencer: per-cycle vector table plus hand-written
// sequences for loop timing, gating, tempo change, stop and mid-play reset.
module tb_note_step_sequencer;

   localparam int NS = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          play = 1'b0;
   logic          wr_en = 1'b0;
   logic [IW-1:0] wr_addr = '0;
   logic [3:0]    wr_note = '0;
   logic [23:0]   step_ticks = 24'd1;
   logic [23:0]   gate_ticks = '0;
   logic [3:0]    note;
   logic [IW-1:0] step_idx;
   logic          step_pulse;
   logic          playing;

   int checks = 0;
   int errors = 0;

   logic [3:0] pat [NS] = '{4'h0, 4'h1, 4'h3, 4'h8, 4'h6, 4'h5, 4'h2, 4'h7};

   typedef struct {
      logic          play;
      logic          wr_en;
      logic [IW-1:0] wr_addr;
      logic [3:0]    wr_note;
      logic [23:0]   st;
      logic [23:0]   gt;
      logic [3:0]    e_note;
      logic [IW-1:0] e_idx;
      logic          e_pulse;
      logic          e_playing;
   } vec_t;

   vec_t tbl [19];

   note_step_sequencer #(.NUM_STEPS(NS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .play       (play),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_note    (wr_note),
      .step_ticks (step_ticks),
      .gate_ticks (gate_ticks),
      .note       (note),
      .step_idx   (step_idx),
      .step_pulse (step_pulse),
      .playing    (playing)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_out(input string name, input logic [3:0] n, input logic [IW-1:0] i,
                            input logic p, input logic pl);
      check({name, ".note"}, 32'(note), 32'(n));
      check({name, ".step_idx"}, 32'(step_idx), 32'(i));
      check({name, ".step_pulse"}, 32'(step_pulse), 32'(p));
      check({name, ".playing"}, 32'(playing), 32'(pl));
   endtask

   task automatic stop_seq(input string name);
      play = 1'b0;
      @(negedge clk);
      check_out(name, 4'hF, '0, 1'b0, 1'b0);
   endtask

   function automatic vec_t mk(input logic pl, input logic we, input logic [IW-1:0] wa,
                               input logic [3:0] wn, input logic [23:0] st, input logic [23:0] gt,
                               input logic [3:0] en, input logic [IW-1:0] ei,
                               input logic ep, input logic epl);
      vec_t v;
      v.play = pl; v.wr_en = we; v.wr_addr = wa; v.wr_note = wn; v.st = st; v.gt = gt;
      v.e_note = en; v.e_idx = ei; v.e_pulse = ep; v.e_playing = epl;
      return v;
   endfunction

   initial begin
      // step_ticks=2 with a 1-cycle gate, then legato, write bypass, step_ticks=0, stop/restart
      tbl[0]  = mk(1, 0, 0, 0, 2, 1, 4'h0, 0, 1, 1);
      tbl[1]  = mk(1, 0, 0, 0, 2, 1, 4'hF, 0, 0, 1);
      tbl[2]  = mk(1, 0, 0, 0, 2, 1, 4'h1, 1, 1, 1);
      tbl[3]  = mk(1, 0, 0, 0, 2, 1, 4'hF, 1, 0, 1);
      tbl[4]  = mk(1, 0, 0, 0, 2, 0, 4'h3, 2, 1, 1);
      tbl[5]  = mk(1, 0, 0, 0, 2, 0, 4'h3, 2, 0, 1);
      tbl[6]  = mk(1, 1, 3, 5, 2, 0, 4'h5, 3, 1, 1);
      tbl[7]  = mk(1, 1, 3, 9, 2, 0, 4'h5, 3, 0, 1);
      tbl[8]  = mk(1, 0, 0, 0, 0, 0, 4'h6, 4, 1, 1);
      tbl[9]  = mk(1, 0, 0, 0, 0, 0, 4'h5, 5, 1, 1);
      tbl[10] = mk(1, 0, 0, 0, 0, 0, 4'h2, 6, 1, 1);
      tbl[11] = mk(1, 0, 0, 0, 0, 0, 4'h7, 7, 1, 1);
      tbl[12] = mk(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1);
      tbl[13] = mk(1, 0, 0, 0, 0, 0, 4'h1, 1, 1, 1);
      tbl[14] = mk(1, 0, 0, 0, 0, 0, 4'h3, 2, 1, 1);
      tbl[15] = mk(1, 0, 0, 0, 0, 0, 4'h9, 3, 1, 1);
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0);
      tbl[17] = mk(1, 0, 0, 0, 0, 0, 4'h0, 0, 1, 1);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0);

      // Reset and idle defaults
      repeat (2) @(negedge clk);
      check_out("in_reset", 4'hF, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check_out("idle", 4'hF, '0, 1'b0, 1'b0);
      end

      // Load the pattern while idle
      for (int i = 0; i < NS; i++) begin
         wr_en = 1'b1; wr_addr = IW'(i); wr_note = pat[i];
         @(negedge clk);
         check_out("write_idle", 4'hF, '0, 1'b0, 1'b0);
      end
      wr_en = 1'b0;

      // Basic loop, legato, 10 cycles per step, wraps 7->0
      step_ticks = 24'd10; gate_ticks = '0; play = 1'b1;
      for (int c = 0; c < 90; c++) begin
         @(negedge clk);
         check_out("loop", pat[(c / 10) % NS], IW'((c / 10) % NS), (c % 10) == 0, 1'b1);
      end
      stop_seq("stop_loop");

      // Gate gap: 6 cycles note, 4 cycles REST
      gate_ticks = 24'd6; play = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check_out("gap", ((c % 10) < 6) ? pat[c / 10] : 4'hF, IW'(c / 10), (c % 10) == 0, 1'b1);
      end
      stop_seq("stop_gap");

      // gate_ticks beyond step length is legato
      gate_ticks = 24'd12; play = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check_out("legato", pat[c / 10], IW'(c / 10), (c % 10) == 0, 1'b1);
      end
      stop_seq("stop_legato");

      // Tempo cut mid-step: tcnt=50, step_ticks 100 -> 20 advances on the next edge
      step_ticks = 24'd100; gate_ticks = '0; play = 1'b1;
      @(negedge clk);
      check_out("tempo_start", pat[0], '0, 1'b1, 1'b1);
      repeat (50) @(negedge clk);
      check_out("tempo_hold", pat[0], '0, 1'b0, 1'b1);
      step_ticks = 24'd20;
      @(negedge clk);
      check_out("tempo_cut", pat[1], 1, 1'b1, 1'b1);
      stop_seq("stop_tempo");

      // Vector table
      for (int k = 0; k < 19; k++) begin
         play = tbl[k].play; wr_en = tbl[k].wr_en; wr_addr = tbl[k].wr_addr;
         wr_note = tbl[k].wr_note; step_ticks = tbl[k].st; gate_ticks = tbl[k].gt;
         @(negedge clk);
         check_out($sformatf("vec%0d", k), tbl[k].e_note, tbl[k].e_idx, tbl[k].e_pulse, tbl[k].e_playing);
      end
      wr_en = 1'b0;

      // Asynchronous reset during step 2, then memory must read back all REST
      step_ticks = 24'd10; gate_ticks = '0; play = 1'b1;
      repeat (25) @(negedge clk);
      check_out("pre_reset", pat[2], 2, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1 check_out("async_reset", 4'hF, '0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1; step_ticks = 24'd1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check_out("mem_cleared", 4'hF, IW'(c % NS), 1'b1, 1'b1);
      end
      stop_seq("stop_final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
